pwm_multi_ramp: RTL and testbench
=================================

Name: pwm_multi_ramp

Overview:
- Next-generation PWM generator: Channels independent PWM outputs share one period counter.
- Each channel has a target duty that is written over a simple write port.
- The applied duty ramps toward the target by at most RampStep per PWM period, and changes only at period boundaries (glitch-free).
- Sits behind the button/data-generator path in front-panel designs and replaces the single-channel generator where several loads must be driven with soft start.

Parameters:
- Size, 5, duty width in bits; M = 2^Size-1 ticks per PWM period; duty D gives D/M high time (D=M is 100 %).
- Channels, 4, number of PWM outputs (1..16).
- ClockPeriod_ns, 20, Clock period.
- PWMPeriod_ns, 200_000, target PWM period; Prescale = max(1, PWMPeriod_ns / (ClockPeriod_ns*M)), integer division.
- PWMType, "Back", "Back" | "Front" | "Center" pulse alignment; any other value behaves as "Back".
- RampStep, 1, maximum duty change per period; 0 means jump straight to target at the next boundary.

Ports:
- Clock  in  1  system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- Enable  in  1  run when high.
- WrEn  in  1  write strobe, one clock.
- WrChan  in  clog2(Channels) (min 1)  channel index for the write.
- WrData  in  Size  new target duty.
- PWM  out  Channels  PWM outputs.
- Synch  out  1  one-clock pulse at period start.
- Settled  out  Channels  high when the channel's applied duty equals its target.

Behaviour:
- Reset (async assert, sync release): prescaler=0, Cnt=0, all targets=0, all applied duties=0, PWM=0, Synch=0, Settled=all ones.
- Tick: asserted when prescaler == Prescale-1; the prescaler then wraps to 0.
- Cnt: advances on each tick through 0..M-1 and wraps to 0.
- Boundary: the tick on which Cnt wraps from M-1 to 0.
- Enable low:
  - prescaler and Cnt held at 0; PWM=0; Synch=0.
  - Writes are still accepted; applied duties are frozen.
- Enable rising: the period restarts at Cnt=0. The first boundary is one full period later. There is no Synch for the restart.
- Write:
  - If WrEn=1 and WrChan<Channels, the target for that channel is updated at the clock edge.
  - If WrChan>=Channels, the write is ignored.
  - Writes never alter the applied duty mid-period.
- Ramp, at each boundary, per channel (A = applied duty, T = target):
  - A<T: A = min(A+RampStep, T).
  - A>T: A = max(A-RampStep, T).
  - RampStep=0: A = T.
  - Arithmetic is done in Size+1 bits; no wrap-around.
- Write and boundary on the same clock: the boundary uses the old target; the new target takes effect from the next boundary.
- Compare, per channel, with the registered Cnt and A:
  - "Back": high when Cnt < A.
  - "Front": high when Cnt >= M-A.
  - "Center": with L=(M-A)>>1, high when L <= Cnt < L+A.
- A=0 gives constant low; A=M gives constant high, with no one-tick glitch at the boundary.
- Registering and latency:
  - PWM is registered: one Clock of latency from Cnt/A.
  - Synch is registered from the same boundary condition, so Synch is high exactly in the clock where PWM first shows the new period.
- Settled[i] = (A==T), registered. It drops the clock after a write that changes the target.
- Reset asserted mid-period: all outputs go to reset values immediately (asynchronously). Targets are lost.

Test Plan:
- Common setup: Size=4, Channels=2, ClockPeriod_ns=20, PWMPeriod_ns=300, giving M=15 and Prescale=1.
- Reset release, Enable=1, no writes -> PWM=00 constantly; Synch pulses every 15 clocks; Settled=11.
- RampStep=0, "Back", write ch0=5 mid-period -> ch0 unchanged until the next Synch, then high 5 of every 15 clocks, with the high time starting at the Synch clock; Settled[0] low until that boundary.
- RampStep=2, write ch1=7 from 0 -> high times over successive periods are 2, 4, 6, 7, 7; Settled[1] rises at the 4th boundary. Then write ch1=0 -> high times 5, 3, 1, 0.
- "Center", A=15 then A=0 -> 15 gives continuous high across boundaries (no glitch); 0 gives continuous low. For A=5, PWM is high for Cnt 5..9.
- Write with WrChan=3, plus a write on the same clock as a boundary -> the WrChan=3 write changes no state; the same-clock write is applied only at the following boundary.
- Reset_n pulled low mid-pulse with ch0 high -> PWM, Synch and Settled reach reset values without waiting for a Clock edge. Enable low for 40 clocks -> PWM=00 and no Synch; after re-enable, the first Synch arrives 15 clocks later.

Source files
------------

// File: rtl/pwm_multi_ramp.sv
// Multi-channel PWM generator. All channels share one prescaled period counter, and each
// channel's applied duty ramps toward its written target once per PWM period.
module pwm_multi_ramp #(
  parameter int    Size           = 5,
  parameter int    Channels       = 4,
  parameter int    ClockPeriod_ns = 20,
  parameter int    PWMPeriod_ns   = 200_000,
  parameter string PWMType        = "Back",
  parameter int    RampStep       = 1,
  localparam int   ChanW          = (Channels > 1) ? $clog2(Channels) : 1
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic                Enable,
  input  logic                WrEn,
  input  logic [ChanW-1:0]    WrChan,
  input  logic [Size-1:0]     WrData,
  output logic [Channels-1:0] PWM,
  output logic                Synch,
  output logic [Channels-1:0] Settled
);

  localparam int M           = (1 << Size) - 1;
  localparam int PrescaleRaw = PWMPeriod_ns / (ClockPeriod_ns * M);
  localparam int Prescale    = (PrescaleRaw < 1) ? 1 : PrescaleRaw;
  localparam int PsW         = (Prescale > 1) ? $clog2(Prescale) : 1;

  localparam logic [PsW-1:0]  PsLast  = PsW'(Prescale - 1);
  localparam logic [Size-1:0] CntLast = Size'(M - 1);
  localparam logic [Size:0]   MaxExt  = (Size + 1)'(M);
  // A step of M or more already reaches any target in one period.
  localparam logic [Size:0]   StepExt = (RampStep >= M) ? MaxExt : (Size + 1)'(RampStep);

  typedef enum logic [1:0] {ALIGN_BACK, ALIGN_FRONT, ALIGN_CENTER} align_e;
  localparam align_e Align = (PWMType == "Front")  ? ALIGN_FRONT  :
                             (PWMType == "Center") ? ALIGN_CENTER : ALIGN_BACK;

  logic [PsW-1:0]  presc;
  logic [Size-1:0] cnt;
  logic [Size-1:0] target  [Channels];
  logic [Size-1:0] applied [Channels];
  logic            wrap_q;
  logic            tick;
  logic            boundary;
  logic            wr_ok;

  assign tick     = Enable && (presc == PsLast);
  assign boundary = tick && (cnt == CntLast);
  assign wr_ok    = WrEn && ({1'b0, WrChan} < (ChanW + 1)'(Channels));

  function automatic logic [Size-1:0] ramp(input logic [Size-1:0] a, input logic [Size-1:0] t);
    logic [Size:0] a_ext;
    logic [Size:0] t_ext;
    logic [Size:0] up;
    logic [Size:0] dn;
    logic [Size-1:0] res;
    a_ext = {1'b0, a};
    t_ext = {1'b0, t};
    up    = a_ext + StepExt;
    dn    = a_ext - StepExt;
    res   = a;
    if (RampStep == 0) begin
      res = t;
    end else if (a_ext < t_ext) begin
      res = (up > t_ext) ? t : up[Size-1:0];
    end else if (a_ext > t_ext) begin
      // Compare before subtracting so a step larger than A never wraps below zero.
      res = (a_ext < t_ext + StepExt) ? t : dn[Size-1:0];
    end
    return res;
  endfunction

  function automatic logic pwm_high(input logic [Size-1:0] c, input logic [Size-1:0] a);
    logic [Size:0] c_ext;
    logic [Size:0] a_ext;
    logic [Size:0] off;
    logic [Size:0] lo;
    logic          hit;
    c_ext = {1'b0, c};
    a_ext = {1'b0, a};
    off   = MaxExt - a_ext;
    lo    = off >> 1;
    if (Align == ALIGN_FRONT) begin
      hit = (c_ext >= off);
    end else if (Align == ALIGN_CENTER) begin
      hit = (c_ext >= lo) && (c_ext < lo + a_ext);
    end else begin
      hit = (c_ext < a_ext);
    end
    return hit;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      presc <= '0;
      cnt   <= '0;
    end else if (!Enable) begin
      presc <= '0;
      cnt   <= '0;
    end else if (tick) begin
      presc <= '0;
      cnt   <= boundary ? '0 : cnt + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // NOTE: the target/applied arrays are reset explicitly; reset must clear every entry, not just outputs.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < Channels; i++) target[i] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < Channels; i++) begin
        if (WrChan == ChanW'(i)) target[i] <= WrData;
      end
    end
  end

  // A write on the boundary clock is not seen here until the next boundary.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < Channels; i++) applied[i] <= '0;
    end else if (boundary) begin
      for (int i = 0; i < Channels; i++) applied[i] <= ramp(applied[i], target[i]);
    end
  end

  // wrap_q marks the clock where Cnt=0 is first registered, so Synch lines up with PWM.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      wrap_q  <= 1'b0;
      Synch   <= 1'b0;
      PWM     <= '0;
      Settled <= '1;
    end else begin
      wrap_q <= boundary;
      Synch  <= Enable & wrap_q;
      for (int i = 0; i < Channels; i++) begin
        PWM[i]     <= Enable & pwm_high(cnt, applied[i]);
        Settled[i] <= (applied[i] == target[i]);
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi_ramp.sv
// Bench for pwm_multi_ramp: four parameter variants share stimulus; a per-clock reference
// model pushes expected outputs to a scoreboard that is popped after each clock edge.
module tb_pwm_multi_ramp;

  localparam int NK = 4;

  typedef struct packed {
    logic [2:0] pwm;
    logic       synch;
    logic [2:0] settled;
  } obs_t;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       wr_en;
  logic [1:0] wr_chan;
  logic [3:0] wr_data;

  logic [1:0] pwm_r0, pwm_r2, pwm_ctr, set_r0, set_r2, set_ctr;
  logic [2:0] pwm_c3, set_c3;
  logic       synch_r0, synch_r2, synch_ctr, synch_c3;

  pwm_multi_ramp #(.Size(4), .Channels(2), .ClockPeriod_ns(20), .PWMPeriod_ns(300),
                   .PWMType("Back"), .RampStep(0)) u_r0 (
    .Clock(clk), .Reset_n(rst_n), .Enable(en), .WrEn(wr_en), .WrChan(wr_chan[0]),
    .WrData(wr_data), .PWM(pwm_r0), .Synch(synch_r0), .Settled(set_r0));

  pwm_multi_ramp #(.Size(4), .Channels(2), .ClockPeriod_ns(20), .PWMPeriod_ns(300),
                   .PWMType("Back"), .RampStep(2)) u_r2 (
    .Clock(clk), .Reset_n(rst_n), .Enable(en), .WrEn(wr_en), .WrChan(wr_chan[0]),
    .WrData(wr_data), .PWM(pwm_r2), .Synch(synch_r2), .Settled(set_r2));

  pwm_multi_ramp #(.Size(4), .Channels(2), .ClockPeriod_ns(20), .PWMPeriod_ns(300),
                   .PWMType("Center"), .RampStep(0)) u_ctr (
    .Clock(clk), .Reset_n(rst_n), .Enable(en), .WrEn(wr_en), .WrChan(wr_chan[0]),
    .WrData(wr_data), .PWM(pwm_ctr), .Synch(synch_ctr), .Settled(set_ctr));

  pwm_multi_ramp #(.Size(4), .Channels(3), .ClockPeriod_ns(20), .PWMPeriod_ns(300),
                   .PWMType("Front"), .RampStep(1)) u_c3 (
    .Clock(clk), .Reset_n(rst_n), .Enable(en), .WrEn(wr_en), .WrChan(wr_chan),
    .WrData(wr_data), .PWM(pwm_c3), .Synch(synch_c3), .Settled(set_c3));

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Instance descriptions: channel count, ramp step, alignment (0 back, 1 front, 2 center).
  int    k_nch   [NK] = '{2, 2, 2, 3};
  int    k_step  [NK] = '{0, 2, 0, 1};
  int    k_align [NK] = '{0, 0, 2, 1};
  string k_name  [NK] = '{"scb_back_step0", "scb_back_step2", "scb_center", "scb_front_3ch"};

  int   m_cnt [NK];
  bit   m_wrap[NK];
  int   m_a   [NK][3];
  int   m_t   [NK][3];
  obs_t m_out [NK];

  obs_t exp_q[$];
  int   exp_hi_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   trk = 1'b0;
  int   hi_cnt = 0;

  function automatic bit ref_high(int al, int c, int a);
    int l;
    l = (15 - a) / 2;
    case (al)
      1:       return c >= 15 - a;
      2:       return (c >= l) && (c < l + a);
      default: return c < a;
    endcase
  endfunction

  // Moves one unit at a time toward the target, up to step units.
  function automatic int ref_ramp(int a, int t, int step);
    int r;
    r = a;
    if (step == 0) return t;
    for (int i = 0; i < step; i++) begin
      if (r < t) r++;
      else if (r > t) r--;
    end
    return r;
  endfunction

  function automatic obs_t observe(int k);
    obs_t o;
    case (k)
      0:       o = '{pwm: {1'b0, pwm_r0},  synch: synch_r0,  settled: {1'b0, set_r0}};
      1:       o = '{pwm: {1'b0, pwm_r2},  synch: synch_r2,  settled: {1'b0, set_r2}};
      2:       o = '{pwm: {1'b0, pwm_ctr}, synch: synch_ctr, settled: {1'b0, set_ctr}};
      default: o = '{pwm: pwm_c3,          synch: synch_c3,  settled: set_c3};
    endcase
    return o;
  endfunction

  task automatic check(string tag, obs_t obs, obs_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed pwm=%b synch=%b settled=%b, expected pwm=%b synch=%b settled=%b",
             tag, obs.pwm, obs.synch, obs.settled, exp.pwm, exp.synch, exp.settled);
    end
  endtask

  task automatic check_int(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NK; k++) begin
      m_cnt[k]  = 0;
      m_wrap[k] = 1'b0;
      for (int c = 0; c < 3; c++) begin
        m_a[k][c] = 0;
        m_t[k][c] = 0;
      end
      m_out[k] = '{pwm: 3'b000, synch: 1'b0, settled: 3'((1 << k_nch[k]) - 1)};
    end
  endtask

  // Advances the model across one clock edge using the inputs as they stand now.
  task automatic model_step();
    bit   bnd;
    int   chan;
    obs_t o;
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int k = 0; k < NK; k++) begin
        o   = '0;
        bnd = en && (m_cnt[k] == 14);
        for (int c = 0; c < k_nch[k]; c++) begin
          o.pwm[c]     = en && ref_high(k_align[k], m_cnt[k], m_a[k][c]);
          o.settled[c] = (m_a[k][c] == m_t[k][c]);
        end
        o.synch   = en && m_wrap[k];
        m_wrap[k] = bnd;
        if (bnd) begin
          for (int c = 0; c < k_nch[k]; c++) m_a[k][c] = ref_ramp(m_a[k][c], m_t[k][c], k_step[k]);
        end
        chan = (k_nch[k] == 3) ? int'(wr_chan) : int'(wr_chan[0]);
        if (wr_en && chan < k_nch[k]) m_t[k][chan] = int'(wr_data);
        m_cnt[k] = !en ? 0 : (m_cnt[k] == 14) ? 0 : m_cnt[k] + 1;
        m_out[k] = o;
      end
    end
  endtask

  task automatic push_expected();
    for (int k = 0; k < NK; k++) exp_q.push_back(m_out[k]);
  endtask

  task automatic compare_all();
    for (int k = 0; k < NK; k++) check(k_name[k], observe(k), exp_q.pop_front());
  endtask

  task automatic cycle();
    int e;
    model_step();
    push_expected();
    @(posedge clk);
    #1;
    compare_all();
    if (trk) begin
      if (synch_r2) begin
        e = (exp_hi_q.size() > 0) ? exp_hi_q.pop_front() : -1;
        check_int("r2_ch1_high_time", hi_cnt, e);
        hi_cnt = int'(pwm_r2[1]);
      end else begin
        hi_cnt += int'(pwm_r2[1]);
      end
    end
  endtask

  task automatic write(int chan, int data);
    wr_en   = 1'b1;
    wr_chan = 2'(chan);
    wr_data = 4'(data);
    cycle();
    wr_en   = 1'b0;
  endtask

  task automatic wait_synch();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (synch_r2) found = 1'b1;
    end
    check_int("synch_wait", int'(found), 1);
  endtask

  initial begin
    int n;
    rst_n = 1'b1; en = 1'b0; wr_en = 1'b0; wr_chan = '0; wr_data = '0;
    #2 rst_n = 1'b0;
    #3;
    model_reset();
    push_expected();
    compare_all();
    repeat (2) cycle();

    // Idle run: duty 0 everywhere, Synch every period.
    rst_n = 1'b1;
    en    = 1'b1;
    repeat (35) cycle();

    // Mid-period write of ch0 = 5.
    wait_synch();
    repeat (4) cycle();
    write(0, 5);
    repeat (35) cycle();

    // Ramp on ch1 of the step-2 instance: up to 7, then back down to 0.
    wait_synch();
    trk    = 1'b1;
    hi_cnt = int'(pwm_r2[1]);
    repeat (5) cycle();
    write(1, 7);
    exp_hi_q.push_back(0); exp_hi_q.push_back(2); exp_hi_q.push_back(4);
    exp_hi_q.push_back(6); exp_hi_q.push_back(7); exp_hi_q.push_back(7);
    repeat (74) cycle();
    write(1, 0);
    exp_hi_q.push_back(5); exp_hi_q.push_back(3); exp_hi_q.push_back(1); exp_hi_q.push_back(0);
    repeat (69) cycle();
    trk = 1'b0;
    check_int("r2_ch1_periods_left", exp_hi_q.size(), 0);

    // Full, zero and mid duty on ch0 (center instance covers the alignment cases).
    write(0, 15);
    repeat (45) cycle();
    write(0, 0);
    repeat (45) cycle();
    write(0, 5);
    repeat (45) cycle();

    // Out-of-range channel for the 3-channel instance, then a write on the boundary clock.
    write(3, 9);
    repeat (10) cycle();
    wait_synch();
    repeat (13) cycle();
    write(0, 12);
    repeat (32) cycle();

    // Asynchronous reset in the middle of a high pulse on ch0.
    wait_synch();
    cycle();
    #5 rst_n = 1'b0;
    #1;
    model_reset();
    push_expected();
    compare_all();
    repeat (2) cycle();
    rst_n = 1'b1;

    // Enable low for 40 clocks, then restart.
    write(0, 9);
    repeat (40) cycle();
    en = 1'b0;
    repeat (40) cycle();
    en = 1'b1;
    cycle();
    n = 0;
    for (int i = 0; i < 30 && !synch_r2; i++) begin
      cycle();
      n++;
    end
    check_int("reenable_first_synch", n, 15);
    repeat (20) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
